shift_sequencer: RTL and testbench

//  Multi-cycle driver for the MIC-1 combinational shifter (SET: 00 pass, 01 SLL8, 10 SRA1, 11 undefined).

---
 rtl/shift_sequencer.sv | 125 ++++++++++++
 tb/tb_shift_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle driver for the MIC-1 shifter: loops one operand through the shifter
// a requested number of times and returns the result over a valid/ready port.
module shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             REQ_valid,
  output logic             REQ_ready,
  input  logic [WIDTH-1:0] REQ_data,
  input  logic [1:0]       REQ_op,
  input  logic [CNT_W-1:0] REQ_amt,
  output logic [WIDTH-1:0] ALU_out,
  output logic [1:0]       SET,
  input  logic [WIDTH-1:0] Shift,
  output logic             RSP_valid,
  input  logic             RSP_ready,
  output logic [WIDTH-1:0] RSP_data,
  output logic             RSP_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [1:0]       r_op;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [1:0]       w_op_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_err_nxt;

  // State and datapath registers
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state <= S_IDLE;
      r_acc   <= {WIDTH{1'b0}};
      r_op    <= 2'b00;
      r_cnt   <= CNT_ZERO;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_op    <= w_op_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state and datapath update; Shift is only consumed while in RUN
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_op_nxt    = r_op;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    case (r_state)
      S_IDLE: begin
        if (REQ_valid) begin
          w_acc_nxt = REQ_data;
          w_op_nxt  = REQ_op;
          w_cnt_nxt = REQ_amt;
          if (REQ_op == 2'b11) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_DONE;
          end else if ((REQ_op == 2'b00) || (REQ_amt == CNT_ZERO)) begin
            w_err_nxt   = 1'b0;
            w_state_nxt = S_DONE;
          end else begin
            w_err_nxt   = 1'b0;
            w_state_nxt = S_RUN;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        w_acc_nxt = Shift;
        w_cnt_nxt = r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        if (RSP_ready) begin
          w_err_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs decode directly from registered state; SET is only non-zero in RUN
  always_comb begin
    REQ_ready = (r_state == S_IDLE);
    RSP_valid = (r_state == S_DONE);
    ALU_out   = r_acc;
    RSP_data  = r_acc;
    RSP_err   = r_err;
    if (r_state == S_RUN) begin
      SET = r_op;
    end else begin
      SET = 2'b00;
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer with a behavioural shifter model.
module tb_shift_sequencer;

  logic        CLK;
  logic        RST_n;
  logic        REQ_valid;
  logic        REQ_ready;
  logic [31:0] REQ_data;
  logic [1:0]  REQ_op;
  logic [4:0]  REQ_amt;
  logic [31:0] ALU_out;
  logic [1:0]  SET;
  logic [31:0] Shift;
  logic        RSP_valid;
  logic        RSP_ready;
  logic [31:0] RSP_data;
  logic        RSP_err;

  int n_assert = 0;
  int n_fail   = 0;
  int set11_cnt = 0;
  int set_nz_cnt = 0;
  int lat;
  int nz_before;
  int rsp_seen;
  logic [1:0]  run_set;
  logic [31:0] run_alu;

  shift_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
    .CLK(CLK), .RST_n(RST_n),
    .REQ_valid(REQ_valid), .REQ_ready(REQ_ready), .REQ_data(REQ_data),
    .REQ_op(REQ_op), .REQ_amt(REQ_amt),
    .ALU_out(ALU_out), .SET(SET), .Shift(Shift),
    .RSP_valid(RSP_valid), .RSP_ready(RSP_ready), .RSP_data(RSP_data), .RSP_err(RSP_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // External shifter; SET=00 returns junk so any sampling outside RUN is visible
  always_comb begin
    case (SET)
      2'b01:   Shift = ALU_out << 8;
      2'b10:   Shift = {ALU_out[31], ALU_out[31:1]};
      default: Shift = 32'hBAD0_BAD0;
    endcase
  end

  always @(negedge CLK) begin
    if (SET == 2'b11) set11_cnt = set11_cnt + 1;
    if (SET != 2'b00) set_nz_cnt = set_nz_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic [1:0] op, input logic [4:0] amt);
    REQ_valid = 1'b1;
    REQ_data  = d;
    REQ_op    = op;
    REQ_amt   = amt;
    @(posedge CLK); #1;
    run_set   = SET;
    run_alu   = ALU_out;
    REQ_valid = 1'b0;
    REQ_data  = 32'h5A5A_A5A5;
    REQ_op    = 2'b11;
    REQ_amt   = 5'd31;
  endtask

  task automatic wait_rsp(output int l);
    l = 1;
    while (!RSP_valid && l < 64) begin
      @(posedge CLK); #1;
      l++;
    end
  endtask

  task automatic handshake;
    RSP_ready = 1'b1;
    @(posedge CLK); #1;
    RSP_ready = 1'b0;
  endtask

  initial begin
    RST_n = 1'b0; REQ_valid = 1'b0; REQ_data = 32'h0; REQ_op = 2'b00;
    REQ_amt = 5'd0; RSP_ready = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK); RST_n = 1'b1;
    @(posedge CLK); #1;
    check("rst_req_ready", {31'd0, REQ_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, RSP_valid}, 32'd0);
    check("rst_rsp_err",   {31'd0, RSP_err},   32'd0);
    check("rst_set",       {30'd0, SET},       32'd0);
    check("rst_alu_out",   ALU_out,            32'h0);

    // 1: single SLL8
    send(32'hAAAA_AAAA, 2'b01, 5'd1);
    check("t1_run_set", {30'd0, run_set}, 32'd1);
    check("t1_run_alu", run_alu, 32'hAAAA_AAAA);
    wait_rsp(lat);
    check("t1_latency", lat, 32'd2);
    check("t1_data", RSP_data, 32'hAAAA_AA00);
    check("t1_err", {31'd0, RSP_err}, 32'd0);
    handshake();
    check("t1_post_valid", {31'd0, RSP_valid}, 32'd0);
    check("t1_post_ready", {31'd0, REQ_ready}, 32'd1);

    // 2: SRA1 single and 31-pass sign fill
    send(32'hAAAA_AAAA, 2'b10, 5'd1);
    wait_rsp(lat);
    check("t2a_data", RSP_data, 32'hD555_5555);
    handshake();
    send(32'h8000_0000, 2'b10, 5'd31);
    wait_rsp(lat);
    check("t2b_latency", lat, 32'd32);
    check("t2b_data", RSP_data, 32'hFFFF_FFFF);
    handshake();

    // 3: SLL8 overflow and pass-through
    send(32'h1234_5678, 2'b01, 5'd5);
    wait_rsp(lat);
    check("t3a_latency", lat, 32'd6);
    check("t3a_data", RSP_data, 32'h0000_0000);
    handshake();
    nz_before = set_nz_cnt;
    send(32'h1234_5678, 2'b00, 5'd7);
    wait_rsp(lat);
    check("t3b_latency", lat, 32'd1);
    check("t3b_data", RSP_data, 32'h1234_5678);
    check("t3b_set_nonzero_cycles", set_nz_cnt - nz_before, 32'd0);
    handshake();

    // 4: illegal op
    send(32'hDEAD_BEEF, 2'b11, 5'd3);
    wait_rsp(lat);
    check("t4_latency", lat, 32'd1);
    check("t4_err", {31'd0, RSP_err}, 32'd1);
    check("t4_data", RSP_data, 32'hDEAD_BEEF);
    handshake();
    check("t4_err_cleared", {31'd0, RSP_err}, 32'd0);

    // 5: backpressure with a competing request held on the input
    send(32'hF000_0000, 2'b10, 5'd2);
    wait_rsp(lat);
    REQ_valid = 1'b1; REQ_data = 32'h1111_1111; REQ_op = 2'b01; REQ_amt = 5'd1;
    for (int i = 0; i < 10; i++) begin
      check("t5_hold_valid", {31'd0, RSP_valid}, 32'd1);
      check("t5_hold_data", RSP_data, 32'hFC00_0000);
      check("t5_hold_req_ready", {31'd0, REQ_ready}, 32'd0);
      @(posedge CLK); #1;
    end
    REQ_valid = 1'b0;
    handshake();
    send(32'h0000_00FF, 2'b01, 5'd1);
    wait_rsp(lat);
    check("t5_resume_latency", lat, 32'd2);
    check("t5_resume_data", RSP_data, 32'h0000_FF00);
    handshake();

    // 6: async reset during RUN
    send(32'h8000_0000, 2'b10, 5'd20);
    repeat (4) begin @(posedge CLK); #1; end
    check("t6_in_run_set", {30'd0, SET}, 32'd2);
    #2 RST_n = 1'b0;
    #1;
    check("t6_rst_req_ready", {31'd0, REQ_ready}, 32'd1);
    check("t6_rst_rsp_valid", {31'd0, RSP_valid}, 32'd0);
    check("t6_rst_set", {30'd0, SET}, 32'd0);
    check("t6_rst_alu_out", ALU_out, 32'h0);
    check("t6_rst_err", {31'd0, RSP_err}, 32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK); RST_n = 1'b1;
    rsp_seen = 0;
    repeat (30) begin
      @(posedge CLK); #1;
      if (RSP_valid) rsp_seen++;
    end
    check("t6_no_rsp_after_rst", rsp_seen, 32'd0);
    check("t6_idle_after_rst", {31'd0, REQ_ready}, 32'd1);

    check("set_never_11", set11_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
